ex_muldiv_unit: RTL and testbench

- Iterative integer multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the latched register operands, funct code, ExOp and flush bit, and owns the architectural HI/LO registers.
- Holds the ID/EX register (and all upstream stages) by asserting stall_o while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_core.sv | 99 +++++++++
 rtl/ex_muldiv_unit.sv | 125 ++++++++++++
 tb/tb_ex_muldiv_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] RTYPE_EXOP_DEF = 3'd2;
    localparam int         ITERS_DEF      = 32;

    localparam logic [5:0] FUN_MFHI  = 6'h10;
    localparam logic [5:0] FUN_MTHI  = 6'h11;
    localparam logic [5:0] FUN_MFLO  = 6'h12;
    localparam logic [5:0] FUN_MTLO  = 6'h13;
    localparam logic [5:0] FUN_MULT  = 6'h18;
    localparam logic [5:0] FUN_MULTU = 6'h19;
    localparam logic [5:0] FUN_DIV   = 6'h1A;
    localparam logic [5:0] FUN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} mdState_t;

    function automatic logic [31:0] absVal(input logic [31:0] v, input logic signedOp);
        return (signedOp && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: MSB-first shift-add multiply and restoring divide on magnitudes,
// with the sign fix-up applied combinationally on the accumulated result.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int ITERS = ITERS_DEF
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        step,
    input  logic        isDiv,
    input  logic        isSigned,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    output logic        lastStep,
    output logic [31:0] resHi,
    output logic [31:0] resLo
);

    localparam int CW = $clog2(ITERS) + 1;

    logic [63:0]   acc;
    logic [63:0]   accNext;
    logic [63:0]   prod;
    logic [31:0]   shiftReg;
    logic [31:0]   addend;
    logic [31:0]   rawA;
    logic [31:0]   quot;
    logic [31:0]   rem;
    logic [32:0]   trial;
    logic [CW-1:0] count;
    logic          divMode;
    logic          divZero;
    logic          negRes;
    logic          negRem;

    // Divide keeps {quotient, remainder} in acc; the remainder stays below the divisor.
    always_comb begin
        trial   = {acc[31:0], shiftReg[31]};
        accNext = acc;
        if (divMode) begin
            if (trial >= {1'b0, addend}) begin
                accNext = {acc[62:32], 1'b1, 32'(trial - {1'b0, addend})};
            end else begin
                accNext = {acc[62:32], 1'b0, trial[31:0]};
            end
        end else begin
            accNext = {acc[62:0], 1'b0} + (shiftReg[31] ? {32'd0, addend} : 64'd0);
        end
    end

    always_comb begin
        quot = negRes ? (~acc[63:32] + 32'd1) : acc[63:32];
        rem  = negRem ? (~acc[31:0] + 32'd1) : acc[31:0];
        prod = negRes ? (~acc + 64'd1) : acc;
        if (divZero) begin
            resHi = rawA;
            resLo = 32'hFFFF_FFFF;
        end else if (divMode) begin
            resHi = rem;
            resLo = quot;
        end else begin
            resHi = prod[63:32];
            resLo = prod[31:0];
        end
    end

    assign lastStep = (count == CW'(ITERS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            count    <= '0;
            shiftReg <= '0;
            addend   <= '0;
            rawA     <= '0;
            divMode  <= 1'b0;
            divZero  <= 1'b0;
            negRes   <= 1'b0;
            negRem   <= 1'b0;
        end else if (start) begin
            acc      <= '0;
            count    <= '0;
            divMode  <= isDiv;
            divZero  <= isDiv && (opB == 32'd0);
            rawA     <= opA;
            negRes   <= isSigned && (opA[31] ^ opB[31]);
            negRem   <= isSigned && isDiv && opA[31];
            shiftReg <= isDiv ? absVal(opA, isSigned) : absVal(opB, isSigned);
            addend   <= isDiv ? absVal(opB, isSigned) : absVal(opA, isSigned);
        end else if (step) begin
            acc      <= accNext;
            count    <= count + CW'(1);
            shiftReg <= {shiftReg[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: decode, sequencing FSM, HI/LO ownership and pipeline stall.
//  state | meaning
//  IDLE  | accepts start ops and MTHI/MTLO, serves MFHI/MFLO
//  ITER  | one multiply/divide step per cycle
//  FIX   | sign-corrected result valid, HI/LO written on exit
//  DONE  | result committed, stall released so the op advances
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter logic [2:0] RTYPE_EXOP = RTYPE_EXOP_DEF,
    parameter int         ITERS      = ITERS_DEF
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_flush,
    input  logic [2:0]  ex_exop,
    input  logic [5:0]  ex_fun,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        kill,
    output logic        stall_o,
    output logic        busy_o,
    output logic [31:0] hilo_rd,
    output logic        hilo_rd_valid,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    mdState_t    state;
    logic [31:0] hiReg;
    logic [31:0] loReg;
    logic        busyReg;
    logic        opValid;
    logic        isMul;
    logic        isDivOp;
    logic        isStart;
    logic        isMf;
    logic        isMt;
    logic        isSigned;
    logic        divByZero;
    logic        coreStart;
    logic        coreStep;
    logic        lastStep;
    logic [31:0] resHi;
    logic [31:0] resLo;

    always_comb begin
        opValid   = !ex_flush && (ex_exop == RTYPE_EXOP);
        isMul     = opValid && (ex_fun == FUN_MULT || ex_fun == FUN_MULTU);
        isDivOp   = opValid && (ex_fun == FUN_DIV || ex_fun == FUN_DIVU);
        isStart   = isMul || isDivOp;
        isMf      = opValid && (ex_fun == FUN_MFHI || ex_fun == FUN_MFLO);
        isMt      = opValid && (ex_fun == FUN_MTHI || ex_fun == FUN_MTLO);
        isSigned  = (ex_fun == FUN_MULT) || (ex_fun == FUN_DIV);
        divByZero = isDivOp && (op_b == 32'd0);
    end

    assign coreStart = (state == IDLE) && isStart && !kill;
    assign coreStep  = (state == ITER) && !kill;

    assign stall_o = !kill && ((isStart && state != DONE) ||
                               ((isMf || isMt) && state != IDLE && state != DONE));

    assign hilo_rd_valid = isMf && (state == IDLE || state == DONE);
    assign hilo_rd       = !hilo_rd_valid ? 32'd0 : ((ex_fun == FUN_MFHI) ? hiReg : loReg);

    assign busy_o = busyReg;
    assign hi_o   = hiReg;
    assign lo_o   = loReg;

    muldiv_core #(.ITERS(ITERS)) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (coreStart),
        .step     (coreStep),
        .isDiv    (isDivOp),
        .isSigned (isSigned),
        .opA      (op_a),
        .opB      (op_b),
        .lastStep (lastStep),
        .resHi    (resHi),
        .resLo    (resLo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busyReg <= 1'b0;
            hiReg   <= '0;
            loReg   <= '0;
        end else if (kill) begin
            state   <= IDLE;
            busyReg <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (isStart) begin
                        state   <= divByZero ? FIX : ITER;
                        busyReg <= 1'b1;
                    end else if (isMt) begin
                        if (ex_fun == FUN_MTHI) hiReg <= op_a;
                        else                    loReg <= op_a;
                    end
                end
                ITER: begin
                    if (lastStep) state <= FIX;
                end
                FIX: begin
                    state <= DONE;
                    hiReg <= resHi;
                    loReg <= resLo;
                end
                DONE: begin
                    state   <= IDLE;
                    busyReg <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busyReg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: reference HI/LO queued at issue, checked when the op leaves EX.
`timescale 1ns/1ps
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_flush = 1'b1;
    logic [2:0]  ex_exop = 3'd0;
    logic [5:0]  ex_fun = 6'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        kill = 1'b0;
    logic        stall_o;
    logic        busy_o;
    logic [31:0] hilo_rd;
    logic        hilo_rd_valid;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int          nVec = 0;
    int          nBad = 0;
    logic [63:0] expQ[$];
    logic [31:0] savedHi;
    logic [31:0] savedLo;

    always #5 clk = ~clk;

    ex_muldiv_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_flush      (ex_flush),
        .ex_exop       (ex_exop),
        .ex_fun        (ex_fun),
        .op_a          (op_a),
        .op_b          (op_b),
        .kill          (kill),
        .stall_o       (stall_o),
        .busy_o        (busy_o),
        .hilo_rd       (hilo_rd),
        .hilo_rd_valid (hilo_rd_valid),
        .hi_o          (hi_o),
        .lo_o          (lo_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nVec++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [5:0] fun, input logic [31:0] a, input logic [31:0] b);
        int     sa;
        int     sb;
        longint sp;
        sa = a;
        sb = b;
        case (fun)
            FUN_MULT: begin
                sp = longint'(sa) * longint'(sb);
                return 64'(sp);
            end
            FUN_MULTU: return {32'd0, a} * {32'd0, b};
            FUN_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            FUN_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic nop();
        ex_flush = 1'b1;
        ex_exop  = 3'd0;
        ex_fun   = 6'd0;
        op_a     = 32'd0;
        op_b     = 32'd0;
    endtask

    task automatic drive(input logic [5:0] fun, input logic [31:0] a, input logic [31:0] b);
        ex_flush = 1'b0;
        ex_exop  = RTYPE_EXOP_DEF;
        ex_fun   = fun;
        op_a     = a;
        op_b     = b;
    endtask

    task automatic runOp(input string tag, input logic [5:0] fun, input logic [31:0] a,
                         input logic [31:0] b, input int expCycles);
        int          cycles;
        logic [63:0] expVal;
        @(negedge clk);
        drive(fun, a, b);
        expQ.push_back(model(fun, a, b));
        #1;
        cycles = 1;
        while (stall_o && cycles < 200) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        chk({tag, " cycles"}, 64'(cycles), 64'(expCycles));
        expVal = expQ.pop_front();
        chk({tag, " hilo"}, {hi_o, lo_o}, expVal);
        @(negedge clk);
        nop();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        logic [5:0] funs[4];
        funs[0] = FUN_MULT;
        funs[1] = FUN_MULTU;
        funs[2] = FUN_DIV;
        funs[3] = FUN_DIVU;

        rst_n = 1'b0;
        nop();
        repeat (2) @(negedge clk);
        chk("rst hi", 64'(hi_o), 64'd0);
        chk("rst lo", 64'(lo_o), 64'd0);
        chk("rst busy", 64'(busy_o), 64'd0);
        chk("rst stall", 64'(stall_o), 64'd0);
        chk("rst rdvalid", 64'(hilo_rd_valid), 64'd0);
        rst_n = 1'b1;

        runOp("mult 7*-3", FUN_MULT, 32'd7, 32'hFFFF_FFFD, 35);
        chk("mult hi const", 64'(hi_o), 64'hFFFF_FFFF);
        chk("mult lo const", 64'(lo_o), 64'hFFFF_FFEB);
        runOp("divu 100/7", FUN_DIVU, 32'd100, 32'd7, 35);
        chk("divu lo const", 64'(lo_o), 64'd14);
        chk("divu hi const", 64'(hi_o), 64'd2);
        runOp("div -7/2", FUN_DIV, 32'hFFFF_FFF9, 32'd2, 35);
        runOp("div ovf", FUN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 35);
        chk("div ovf lo", 64'(lo_o), 64'h8000_0000);
        runOp("divu 5/0", FUN_DIVU, 32'd5, 32'd0, 3);
        runOp("div neg/0", FUN_DIV, 32'hFFFF_FFF0, 32'd0, 3);
        runOp("multu max", FUN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35);

        @(negedge clk);
        drive(FUN_MFLO, 32'd0, 32'd0);
        #1;
        chk("mflo data", 64'(hilo_rd), 64'd1);
        chk("mflo valid", 64'(hilo_rd_valid), 64'd1);
        chk("mflo stall", 64'(stall_o), 64'd0);
        ex_fun = FUN_MFHI;
        #1;
        chk("mfhi data", 64'(hilo_rd), 64'hFFFF_FFFE);

        for (int k = 0; k < 10; k++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = (k % 2 == 0) ? $urandom : (($urandom_range(0, 1) == 1) ? -$urandom_range(1, 40) : $urandom_range(1, 40));
            runOp("random", funs[k % 4], ra, rb, 35);
        end

        @(negedge clk);
        drive(FUN_MTHI, 32'h0000_DEAD, 32'd0);
        #1;
        chk("mthi stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        nop();
        #1;
        chk("mthi hi", 64'(hi_o), 64'h0000_DEAD);
        drive(FUN_MTHI, 32'h0000_BEEF, 32'd0);
        ex_flush = 1'b1;
        #1;
        chk("mthi flushed stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        nop();
        #1;
        chk("mthi flushed hi", 64'(hi_o), 64'h0000_DEAD);
        drive(FUN_MTLO, 32'h0000_1234, 32'd0);
        @(negedge clk);
        nop();
        #1;
        chk("mtlo lo", 64'(lo_o), 64'h0000_1234);

        savedHi = hi_o;
        savedLo = lo_o;
        @(negedge clk);
        drive(FUN_MULT, 32'd3, 32'd5);
        repeat (4) @(negedge clk);
        ex_fun = FUN_MFHI;
        #1;
        chk("mfhi busy stall", 64'(stall_o), 64'd1);
        chk("mfhi busy valid", 64'(hilo_rd_valid), 64'd0);
        chk("mfhi busy data", 64'(hilo_rd), 64'd0);
        ex_fun = FUN_MULT;
        repeat (6) @(negedge clk);
        #1;
        chk("kill pre busy", 64'(busy_o), 64'd1);
        kill = 1'b1;
        #1;
        chk("kill stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        kill = 1'b0;
        nop();
        #1;
        chk("kill busy", 64'(busy_o), 64'd0);
        chk("kill hilo", {hi_o, lo_o}, {savedHi, savedLo});

        @(negedge clk);
        drive(FUN_DIVU, 32'd1000, 32'd3);
        repeat (33) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        nop();
        #1;
        chk("kill fix busy", 64'(busy_o), 64'd0);
        chk("kill fix hilo", {hi_o, lo_o}, {savedHi, savedLo});

        @(negedge clk);
        drive(FUN_MULT, 32'd9, 32'd11);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        nop();
        #1;
        chk("areset busy", 64'(busy_o), 64'd0);
        chk("areset hilo", {hi_o, lo_o}, 64'd0);
        chk("areset stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        runOp("post reset divu", FUN_DIVU, 32'd1000, 32'd10, 35);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
